seq_mul_bcd_disp: RTL

SEQ_MUL_BCD_DISP -- requirements
Module: seq_mul_bcd_disp

---
 rtl/seq_mul_bcd_disp_if.sv | 17 +
 rtl/seq_mul_bcd_disp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_mul_bcd_disp_if.sv
// Request/result bundle for seq_mul_bcd_disp: operands in, binary, BCD and segment results out.
interface seq_mul_bcd_disp_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 5
);
  logic             start;
  logic [W-1:0]     ina;
  logic [W-1:0]     inb;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;
  logic [4*D-1:0]   bcd;
  logic [7*D-1:0]   seg;

  modport master (output start, ina, inb, input busy, done, product, bcd, seg);
  modport slave  (input start, ina, inb, output busy, done, product, bcd, seg);
endinterface

// File: rtl/seq_mul_bcd_disp.sv
// Sequential shift-add multiplier followed by double-dabble BCD conversion and 7-segment decode.
// Optional macro LEAD_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module seq_mul_bcd_disp #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_mul_bcd_disp_if.slave  bus
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned BW = 4 * D;
  localparam int unsigned SW = 7 * D;
  localparam int unsigned CW = $clog2(PW) + 1;

  typedef enum logic [1:0] {IDLE, MUL, CONV} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  ma;
  logic [W-1:0]   mb;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  sbin;
  logic [BW-1:0]  bwork;
  logic [PW-1:0]  product_q;
  logic [BW-1:0]  bcd_q;
  logic [SW-1:0]  seg_q;
  logic           busy_q;
  logic           done_q;

  logic [PW-1:0]  acc_add;
  logic [BW-1:0]  adj;
  logic [BW-1:0]  bwork_nxt;
  logic [SW-1:0]  seg_nxt;
  logic [3:0]     dig;
  logic           lit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign acc_add = mb[0] ? acc + ma : acc;

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next product bit.
  always_comb begin
    adj = bwork;
    for (int i = 0; i < int'(D); i++) begin
      if (bwork[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bwork[4*i +: 4] + 4'd3;
    end
    bwork_nxt = {adj[BW-2:0], sbin[PW-1]};
  end

  // Decode walks from the top digit down so blanking can stop at the first non-zero digit.
  always_comb begin
    seg_nxt = '0;
    dig     = '0;
    lit     = 1'b0;
    for (int i = int'(D) - 1; i >= 0; i--) begin
      dig = bwork_nxt[4*i +: 4];
`ifdef LEAD_ZERO_BLANK_EN
      lit = lit | (dig != 4'd0) | (i == 0);
`else
      lit = 1'b1;
`endif
      seg_nxt[7*i +: 7] = lit ? seg7(dig) : 7'b0000000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      sbin      <= '0;
      bwork     <= '0;
      product_q <= '0;
      bcd_q     <= '0;
      seg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ma     <= PW'(bus.ina);
            mb     <= bus.inb;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          acc <= acc_add;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          if (cnt == CW'(W - 1)) begin
            cnt   <= '0;
            sbin  <= acc_add;
            bwork <= '0;
            state <= CONV;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CONV: begin
          sbin  <= sbin << 1;
          bwork <= bwork_nxt;
          if (cnt == CW'(PW - 1)) begin
            product_q <= acc;
            bcd_q     <= bwork_nxt;
            seg_q     <= seg_nxt;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.bcd     = bcd_q;
  assign bus.seg     = seg_q;

endmodule
